// File: rtl/beat_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : beat_scheduler
// Description : 8-step, 2-track drum sequencer clocked by audio sample strobes,
//               with play/pause/stop control and double-buffered patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module beat_scheduler #(
  parameter int GATE_LEN    = 2400,
  parameter int RESET_TEMPO = 6000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        advance,
  input  logic        cmd_play,
  input  logic        cmd_stop,
  input  logic [15:0] tempo,
  input  logic        pat_wr,
  input  logic        pat_track,
  input  logic [7:0]  pat_data,
  output logic        pat_ack,
  output logic [2:0]  beat,
  output logic        step_strobe,
  output logic [1:0]  gate,
  output logic        running
);

  localparam logic [1:0]  c_idle        = 2'd0;
  localparam logic [1:0]  c_run         = 2'd1;
  localparam logic [1:0]  c_pause       = 2'd2;
  localparam logic [31:0] c_gate_len    = GATE_LEN;
  localparam logic [15:0] c_reset_tempo = RESET_TEMPO[15:0];

  logic [1:0]  r_state;
  logic [15:0] r_counter;
  logic [15:0] r_tempo_l;
  logic [2:0]  r_beat;
  logic        r_strobe;
  logic [1:0]  r_gate;
  logic        r_ack;
  logic [1:0]  r_pending;
  logic [7:0]  r_staged [2];
  logic [7:0]  r_active [2];

  logic        w_start;
  logic        w_stay_run;
  logic        w_boundary;
  logic        w_wr;
  logic        w_gate_window;
  logic [15:0] w_tempo_in;

  assign w_start       = (r_state == c_idle) && cmd_play && !cmd_stop;
  // Cycles that leave RUN neither count samples nor open a gate.
  assign w_stay_run    = (r_state == c_run) && !cmd_play && !cmd_stop;
  assign w_boundary    = w_stay_run && advance && (r_counter == r_tempo_l - 16'd1);
  assign w_wr          = pat_wr && !r_ack;
  assign w_gate_window = ({16'd0, r_counter} < c_gate_len);
  assign w_tempo_in    = (tempo == 16'd0) ? 16'd1 : tempo;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state   <= c_idle;
      r_counter <= 16'd0;
      r_tempo_l <= c_reset_tempo;
      r_beat    <= 3'd0;
      r_strobe  <= 1'b0;
      r_gate    <= 2'b00;
      r_ack     <= 1'b0;
      r_pending <= 2'b00;
      for (int t = 0; t < 2; t++) begin
        r_staged[t] <= 8'd0;
        r_active[t] <= 8'd0;
      end
    end else begin
      r_strobe <= w_start || w_boundary;
      r_ack    <= w_wr;

      if (cmd_stop) begin
        r_state   <= c_idle;
        r_beat    <= 3'd0;
        r_counter <= 16'd0;
      end else if (cmd_play) begin
        case (r_state)
          c_idle: begin
            r_state   <= c_run;
            r_beat    <= 3'd0;
            r_counter <= 16'd0;
            r_tempo_l <= w_tempo_in;
          end
          c_run:   r_state <= c_pause;
          c_pause: r_state <= c_run;
          default: r_state <= c_idle;
        endcase
      end else if (w_boundary) begin
        r_counter <= 16'd0;
        r_beat    <= r_beat + 3'd1;
        r_tempo_l <= w_tempo_in;
      end else if ((r_state == c_run) && advance) begin
        r_counter <= r_counter + 16'd1;
      end

      for (int t = 0; t < 2; t++) begin
        r_gate[t] <= w_stay_run && r_active[t][r_beat] && w_gate_window;

        // Commit reads the pre-write staged value, so a write landing on a
        // boundary stays pending until the following boundary.
        if (r_pending[t] && (w_boundary || (r_state != c_run)))
          r_active[t] <= r_staged[t];

        if (w_wr && (pat_track == 1'(t))) begin
          r_staged[t]  <= pat_data;
          r_pending[t] <= 1'b1;
        end else if (r_pending[t] && (w_boundary || (r_state != c_run))) begin
          r_pending[t] <= 1'b0;
        end
      end
    end
  end

  assign pat_ack     = r_ack;
  assign beat        = r_beat;
  assign step_strobe = r_strobe;
  assign gate        = r_gate;
  assign running     = (r_state == c_run);

endmodule
`default_nettype wire

// File: tb/tb_beat_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_beat_scheduler
// Description : Self-checking scenario bench for beat_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beat_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        advance;
  logic        cmd_play;
  logic        cmd_stop;
  logic [15:0] tempo;
  logic        pat_wr;
  logic        pat_track;
  logic [7:0]  pat_data;
  logic        pat_ack;
  logic [2:0]  beat;
  logic        step_strobe;
  logic [1:0]  gate;
  logic        running;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int gate_q[$];

  beat_scheduler #(.GATE_LEN(2400), .RESET_TEMPO(6000)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .advance     (advance),
    .cmd_play    (cmd_play),
    .cmd_stop    (cmd_stop),
    .tempo       (tempo),
    .pat_wr      (pat_wr),
    .pat_track   (pat_track),
    .pat_data    (pat_data),
    .pat_ack     (pat_ack),
    .beat        (beat),
    .step_strobe (step_strobe),
    .gate        (gate),
    .running     (running)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b0; advance = 1'b0; cmd_play = 1'b0; cmd_stop = 1'b0;
    tempo = 16'd4; pat_wr = 1'b0; pat_track = 1'b0; pat_data = 8'h00;
    repeat (3) tick();
    n_checks++; if (beat !== 3'd0) $display("FAIL reset_beat: got %0d want 0", beat); else n_pass++;
    n_checks++; if (step_strobe !== 1'b0) $display("FAIL reset_strobe: got %0b want 0", step_strobe); else n_pass++;
    n_checks++; if (gate !== 2'b00) $display("FAIL reset_gate: got %b want 00", gate); else n_pass++;
    n_checks++; if ({running, pat_ack} !== 2'b00) $display("FAIL reset_run_ack: got %b want 00", {running, pat_ack}); else n_pass++;
    reset = 1'b1;
    advance = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({beat, step_strobe, gate, running, pat_ack} !== 8'd0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL post_release_quiet: got %0d changed cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_pattern_play();
    logic [7:0] pat;
    int last;
    int seen;
    pat = 8'b0001_0001;
    pat_wr = 1'b1; pat_track = 1'b0; pat_data = pat;
    tick();
    n_checks++; if (pat_ack !== 1'b1) $display("FAIL idle_write_ack: got %0b want 1", pat_ack); else n_pass++;
    pat_wr = 1'b0;
    tick();
    n_checks++; if (pat_ack !== 1'b0) $display("FAIL idle_ack_drop: got %0b want 0", pat_ack); else n_pass++;
    tempo = 16'd4;
    advance = 1'b1;
    cmd_play = 1'b1;
    for (int b = 0; b < 9; b++) exp_q.push_back(b % 8);
    tick();
    cmd_play = 1'b0;
    n_checks++; if (running !== 1'b1) $display("FAIL play_running: got %0b want 1", running); else n_pass++;
    last = -1;
    seen = 0;
    for (int c = 0; c < 45 && (exp_q.size() > 0 || gate_q.size() > 0); c++) begin
      if (gate_q.size() > 0) begin
        int g;
        g = gate_q.pop_front();
        n_checks++; if (gate[0] !== g[0]) $display("FAIL gate0_step: got %0b want %0d", gate[0], g); else n_pass++;
      end
      if (step_strobe === 1'b1) begin
        int eb;
        seen++;
        if (exp_q.size() == 0) begin
          n_checks++; $display("FAIL extra_strobe: got strobe at cycle %0d want none", c);
        end else begin
          eb = exp_q.pop_front();
          n_checks++; if (beat !== eb[2:0]) $display("FAIL seq_beat: got %0d want %0d", beat, eb); else n_pass++;
          if (last >= 0) begin
            n_checks++; if (c - last !== 4) $display("FAIL strobe_period: got %0d want 4", c - last); else n_pass++;
          end
          last = c;
          gate_q.push_back(int'(pat[eb[2:0]]));
        end
      end
      tick();
    end
    n_checks++; if (seen !== 9) $display("FAIL seq_strobe_count: got %0d want 9", seen); else n_pass++;
    exp_q.delete();
    gate_q.delete();
  endtask

  task automatic test_midstep_write();
    int bad;
    int found;
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      tick();
      if (step_strobe === 1'b1 && beat === 3'd2) found = 1;
    end
    n_checks++; if (found !== 1) $display("FAIL wait_beat2: got %0d want 1", found); else n_pass++;
    tick();
    pat_wr = 1'b1; pat_track = 1'b1; pat_data = 8'hFF;
    tick();
    pat_wr = 1'b0;
    n_checks++; if (pat_ack !== 1'b1) $display("FAIL run_write_ack: got %0b want 1", pat_ack); else n_pass++;
    bad = 0;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      if (gate[1] !== 1'b0) bad++;
      tick();
      if (step_strobe === 1'b1) found = 1;
    end
    if (gate[1] !== 1'b0) bad++;
    n_checks++; if (bad !== 0) $display("FAIL gate1_early: got %0d high cycles want 0", bad); else n_pass++;
    n_checks++; if (beat !== 3'd3) $display("FAIL beat3_strobe: got %0d want 3", beat); else n_pass++;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (gate[1] !== 1'b1) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL gate1_on: got %0d low cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_pause();
    int bad;
    int found;
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      tick();
      if (step_strobe === 1'b1 && beat === 3'd5) found = 1;
    end
    n_checks++; if (found !== 1) $display("FAIL wait_beat5: got %0d want 1", found); else n_pass++;
    tick();
    tick();
    cmd_play = 1'b1;
    tick();
    cmd_play = 1'b0;
    n_checks++; if ({running, gate} !== 3'b000) $display("FAIL pause_enter: got %b want 000", {running, gate}); else n_pass++;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (beat !== 3'd5 || step_strobe !== 1'b0 || gate !== 2'b00 || running !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL pause_hold: got %0d bad cycles want 0", bad); else n_pass++;
    exp_q.push_back(6);
    cmd_play = 1'b1;
    tick();
    cmd_play = 1'b0;
    n_checks++; if ({running, step_strobe, beat} !== 5'b1_0_101) $display("FAIL resume: got %b want 10101", {running, step_strobe, beat}); else n_pass++;
    tick();
    n_checks++; if (step_strobe !== 1'b0) $display("FAIL resume_no_strobe: got %0b want 0", step_strobe); else n_pass++;
    tick();
    begin
      int eb;
      eb = exp_q.pop_front();
      n_checks++; if ({step_strobe, beat} !== {1'b1, eb[2:0]}) $display("FAIL resume_count: got strobe %0b beat %0d want 1 %0d", step_strobe, beat, eb); else n_pass++;
    end
  endtask

  task automatic test_stop_priority();
    int bad;
    cmd_play = 1'b1; cmd_stop = 1'b1;
    tick();
    cmd_play = 1'b0; cmd_stop = 1'b0;
    n_checks++; if ({running, beat} !== 4'b0_000) $display("FAIL stop_wins: got %b want 0000", {running, beat}); else n_pass++;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if ({running, step_strobe, beat, gate} !== 7'd0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL stop_idle_hold: got %0d bad cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_tempo();
    int bad;
    tempo = 16'd0;
    cmd_play = 1'b1;
    for (int b = 0; b < 6; b++) exp_q.push_back(b);
    tick();
    cmd_play = 1'b0;
    for (int c = 0; c < 6; c++) begin
      int eb;
      eb = exp_q.pop_front();
      n_checks++; if ({step_strobe, beat} !== {1'b1, eb[2:0]}) $display("FAIL tempo0_step: got strobe %0b beat %0d want 1 %0d", step_strobe, beat, eb); else n_pass++;
      tick();
    end
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    tempo = 16'd4;
    cmd_play = 1'b1;
    tick();
    cmd_play = 1'b0;
    tick();
    tempo = 16'd8;
    bad = 0;
    for (int c = 2; c <= 12; c++) begin
      tick();
      if (c == 4) begin
        n_checks++; if ({step_strobe, beat} !== 4'b1_001) $display("FAIL tempo_old_step: got %b want 1001", {step_strobe, beat}); else n_pass++;
      end else if (c == 12) begin
        n_checks++; if ({step_strobe, beat} !== 4'b1_010) $display("FAIL tempo_new_step: got %b want 1010", {step_strobe, beat}); else n_pass++;
      end else if (step_strobe !== 1'b0) begin
        bad++;
      end
    end
    n_checks++; if (bad !== 0) $display("FAIL tempo_stray_strobe: got %0d want 0", bad); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int bad;
    int strobes;
    int found;
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    tempo = 16'd4;
    cmd_play = 1'b1;
    tick();
    cmd_play = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      tick();
      if (step_strobe === 1'b1 && beat === 3'd6) found = 1;
    end
    n_checks++; if (found !== 1) $display("FAIL wait_beat6: got %0d want 1", found); else n_pass++;
    tick();
    pat_wr = 1'b1; pat_track = 1'b0; pat_data = 8'hFF;
    tick();
    pat_wr = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if ({beat, step_strobe, gate, running, pat_ack} !== 8'd0) $display("FAIL async_reset: got %b want 00000000", {beat, step_strobe, gate, running, pat_ack}); else n_pass++;
    tick();
    tick();
    reset = 1'b1;
    tick();
    cmd_play = 1'b1;
    tick();
    cmd_play = 1'b0;
    bad = 0;
    strobes = 0;
    for (int c = 0; c < 40; c++) begin
      if (gate !== 2'b00) bad++;
      if (step_strobe === 1'b1) strobes++;
      tick();
    end
    n_checks++; if (bad !== 0) $display("FAIL silent_after_reset: got %0d gated cycles want 0", bad); else n_pass++;
    n_checks++; if (strobes !== 10) $display("FAIL strobes_after_reset: got %0d want 10", strobes); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pattern_play();
    test_midstep_write();
    test_pause();
    test_stop_priority();
    test_tempo();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
